// File: rtl/serial_add_ctrl_pkg.sv
// Shared types and constants for the serial adder/subtractor controller.
package serial_add_pkg;

  // Bits consumed per step by the ripple slice.
  localparam int SLICE_W = 2;

  // Encoding 2'd3 is unused and decodes back to IDLE.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Start/done request bus between a requester and the serial adder.
interface serial_add_ctrl_if #(parameter int WIDTH = 8);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (output start, sub, a, b, input busy, done, sum, cout, ovf);
  modport slave  (input start, sub, a, b, output busy, done, sum, cout, ovf);
endinterface

// File: rtl/serial_add_ctrl_slice.sv
// Two-bit ripple slice built from two full adders; the LSB carry-in is exposed
// so the controller can feed back the carry flop (and inject +1 for subtract).
module full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_s,
  output logic o_cout
);
  assign o_s    = i_a ^ i_b ^ i_cin;
  assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));
endmodule

module adder_slice2
  import serial_add_pkg::*;
(
  input  logic [SLICE_W-1:0] i_a,
  input  logic [SLICE_W-1:0] i_b,
  input  logic               i_cin,
  output logic [SLICE_W-1:0] o_s,
  output logic               o_cout
);
  logic w_c1;

  full_adder u_fa0 (.i_a(i_a[0]), .i_b(i_b[0]), .i_cin(i_cin), .o_s(o_s[0]), .o_cout(w_c1));
  full_adder u_fa1 (.i_a(i_a[1]), .i_b(i_b[1]), .i_cin(w_c1),  .o_s(o_s[1]), .o_cout(o_cout));
endmodule

// File: rtl/serial_add_ctrl.sv
// Multi-cycle adder/subtractor: one 2-bit slice stepped WIDTH/2 times, LSB pair
// first, with the carry held in a flop between steps. Results are registered
// on entry to DONE and held until the next operation completes.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  serial_add_ctrl_if.slave bus
);

  localparam int STEPS = WIDTH / SLICE_W;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STEPS - 1);

  if ((WIDTH < 2) || ((WIDTH % 2) != 0)) begin : g_bad_width
    $error("serial_add_ctrl: WIDTH must be even and >= 2");
  end

  state_e             r_state, w_next;
  logic [WIDTH-1:0]   r_a_sh, r_b_sh, r_sum_sh;
  logic               r_carry;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_a_msb, r_b_msb;
  logic [WIDTH-1:0]   r_sum;
  logic               r_cout, r_ovf;

  logic               w_load, w_last;
  logic [WIDTH-1:0]   w_b_eff, w_sum_next;
  logic [SLICE_W-1:0] w_slice_s;
  logic               w_slice_c;

  // DONE doubles as an accept slot so back-to-back requests lose no cycle.
  assign w_load  = bus.start && ((r_state == IDLE) || (r_state == DONE));
  assign w_last  = (r_state == RUN) && (r_cnt == LAST_CNT);
  assign w_b_eff = bus.sub ? ~bus.b : bus.b;

  adder_slice2 u_slice (
    .i_a   (r_a_sh[SLICE_W-1:0]),
    .i_b   (r_b_sh[SLICE_W-1:0]),
    .i_cin (r_carry),
    .o_s   (w_slice_s),
    .o_cout(w_slice_c)
  );

  // Slice result enters from the top so after the final step the LSB pair has
  // reached bit 0; written as shifts so WIDTH=2 needs no special case.
  assign w_sum_next = (r_sum_sh >> SLICE_W) | (WIDTH'(w_slice_s) << (WIDTH - SLICE_W));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next-state decode and status outputs.
  always_comb begin
    w_next   = r_state;
    bus.busy = 1'b0;
    bus.done = 1'b0;
    case (r_state)
      IDLE: if (bus.start) w_next = RUN;
      RUN: begin
        bus.busy = 1'b1;
        if (r_cnt == LAST_CNT) w_next = DONE;
      end
      DONE: begin
        bus.done = 1'b1;
        w_next   = bus.start ? RUN : IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Operand capture, per-step shifting/carry, and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_sum_sh <= '0;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
      r_a_msb  <= 1'b0;
      r_b_msb  <= 1'b0;
      r_sum    <= '0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
    end else if (w_load) begin
      r_a_sh  <= bus.a;
      r_b_sh  <= w_b_eff;
      r_carry <= bus.sub;
      r_cnt   <= '0;
      r_a_msb <= bus.a[WIDTH-1];
      r_b_msb <= w_b_eff[WIDTH-1];
    end else if (r_state == RUN) begin
      r_a_sh   <= r_a_sh >> SLICE_W;
      r_b_sh   <= r_b_sh >> SLICE_W;
      r_sum_sh <= w_sum_next;
      r_carry  <= w_slice_c;
      r_cnt    <= r_cnt + 1'b1;
      if (w_last) begin
        r_sum  <= w_sum_next;
        r_cout <= w_slice_c;
        r_ovf  <= (r_a_msb == r_b_msb) && (w_sum_next[WIDTH-1] != r_a_msb);
      end
    end
  end

  assign bus.sum  = r_sum;
  assign bus.cout = r_cout;
  assign bus.ovf  = r_ovf;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed and model-based bench for serial_add_ctrl at WIDTH 2, 8 and 16.
module tb_serial_add_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  serial_add_ctrl_if #(.WIDTH(2))  b2  ();
  serial_add_ctrl_if #(.WIDTH(8))  b8  ();
  serial_add_ctrl_if #(.WIDTH(16)) b16 ();

  serial_add_ctrl #(.WIDTH(2))  u_dut2  (.clk(clk), .rst(rst), .bus(b2));
  serial_add_ctrl #(.WIDTH(8))  u_dut8  (.clk(clk), .rst(rst), .bus(b8));
  serial_add_ctrl #(.WIDTH(16)) u_dut16 (.clk(clk), .rst(rst), .bus(b16));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic drive(input int w, input logic [15:0] a, input logic [15:0] b,
                       input logic sub, input logic st);
    case (w)
      2:  begin b2.start = st;  b2.a = a[1:0];  b2.b = b[1:0];  b2.sub = sub;  end
      8:  begin b8.start = st;  b8.a = a[7:0];  b8.b = b[7:0];  b8.sub = sub;  end
      default: begin b16.start = st; b16.a = a; b16.b = b; b16.sub = sub; end
    endcase
  endtask

  function automatic logic get_done(input int w);
    return (w == 2) ? b2.done : (w == 8) ? b8.done : b16.done;
  endfunction

  task automatic get_res(input int w, output logic [15:0] s, output logic c, output logic o);
    case (w)
      2:  begin s = 16'(b2.sum);  c = b2.cout;  o = b2.ovf;  end
      8:  begin s = 16'(b8.sum);  c = b8.cout;  o = b8.ovf;  end
      default: begin s = b16.sum; c = b16.cout; o = b16.ovf; end
    endcase
  endtask

  // Independent reference: integer arithmetic with signed range check.
  task automatic model(input int w, input logic [15:0] a, input logic [15:0] b, input logic sub,
                       output logic [15:0] s, output logic c, output logic o);
    int ua, ub, sa, sb, r;
    ua = int'(a); ub = int'(b); sa = ua; sb = ub;
    if (a[w-1]) sa -= (1 << w);
    if (b[w-1]) sb -= (1 << w);
    r = sub ? (sa - sb) : (sa + sb);
    o = (r > ((1 << (w-1)) - 1)) || (r < -(1 << (w-1)));
    c = sub ? (ua >= ub) : ((ua + ub) >= (1 << w));
    s = 16'((sub ? (ua - ub) : (ua + ub)) & ((1 << w) - 1));
  endtask

  // Present one request, scramble operands after acceptance, and wait for done.
  // lat counts falling edges after the accepting one; expected WIDTH/2.
  task automatic run_op(input int w, input logic [15:0] a, input logic [15:0] b, input logic sub,
                        output logic [15:0] s, output logic c, output logic o, output int lat);
    @(negedge clk);
    drive(w, a, b, sub, 1'b1);
    @(negedge clk);
    drive(w, 16'($urandom), 16'($urandom), 1'($urandom), 1'b0);
    lat = 0;
    while (!get_done(w) && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    get_res(w, s, c, o);
  endtask

  // Protocol checks: done is a single-cycle pulse and never overlaps busy.
  logic p2 = 0, p8 = 0, p16 = 0;
  always @(negedge clk) begin
    if (!rst) begin
      n_cmp++;
      if ((b2.busy && b2.done) || (b8.busy && b8.done) || (b16.busy && b16.done)) begin
        n_bad++;
        $display("FAIL busy_and_done: b2=%b%b b8=%b%b b16=%b%b required no overlap",
                 b2.busy, b2.done, b8.busy, b8.done, b16.busy, b16.done);
      end
      n_cmp++;
      if ((p2 && b2.done) || (p8 && b8.done) || (p16 && b16.done)) begin
        n_bad++;
        $display("FAIL done_width: done high two cycles (w2=%b w8=%b w16=%b) required 1-cycle pulse",
                 p2 && b2.done, p8 && b8.done, p16 && b16.done);
      end
    end
    p2 = b2.done; p8 = b8.done; p16 = b16.done;
  end

  task automatic test_reset();
    drive(2, 0, 0, 0, 0); drive(8, 0, 0, 0, 0); drive(16, 0, 0, 0, 0);
    rst = 1'b1;
    #12;
    n_cmp++;
    if ({b8.busy, b8.done, b8.sum, b8.cout, b8.ovf} !== 11'd0) begin
      n_bad++;
      $display("FAIL reset_w8: got %b required 0", {b8.busy, b8.done, b8.sum, b8.cout, b8.ovf});
    end
    n_cmp++;
    if ({b2.busy, b2.done, b2.sum, b16.busy, b16.done, b16.sum, b16.cout, b16.ovf} !== 24'd0) begin
      n_bad++;
      $display("FAIL reset_w2_w16: outputs not all zero");
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [7:0]  ta [4] = '{8'h5A, 8'hFF, 8'h10, 8'h80};
    logic [7:0]  tb [4] = '{8'h3C, 8'h01, 8'h20, 8'h01};
    logic        ts [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [7:0]  es [4] = '{8'h96, 8'h00, 8'hF0, 8'h7F};
    logic        ec [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic        eo [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [15:0] s; logic c, o; int lat;
    for (int i = 0; i < 4; i++) begin
      run_op(8, 16'(ta[i]), 16'(tb[i]), ts[i], s, c, o, lat);
      n_cmp++;
      if ({s[7:0], c, o} !== {es[i], ec[i], eo[i]}) begin
        n_bad++;
        $display("FAIL directed_%0d: got sum=%h cout=%b ovf=%b required sum=%h cout=%b ovf=%b",
                 i, s[7:0], c, o, es[i], ec[i], eo[i]);
      end
      n_cmp++;
      if (lat !== 4) begin
        n_bad++;
        $display("FAIL latency_%0d: got %0d required 4", i, lat);
      end
    end
  endtask

  task automatic test_ignore_start();
    int busy_cnt = 0, extra_done = 0;
    @(negedge clk);
    drive(8, 16'h5A, 16'h3C, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (b8.busy) busy_cnt++;
      drive(8, 16'h01, 16'h01, 1'b1, 1'b1);
    end
    @(negedge clk);
    drive(8, 16'h01, 16'h01, 1'b1, 1'b0);
    n_cmp++;
    if ({b8.done, b8.sum, b8.cout, b8.ovf} !== {1'b1, 8'h96, 1'b0, 1'b1} || busy_cnt != 4) begin
      n_bad++;
      $display("FAIL ignore_start: got done=%b sum=%h busy_cycles=%0d required done=1 sum=96 busy_cycles=4",
               b8.done, b8.sum, busy_cnt);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (b8.done || b8.busy) extra_done++;
    end
    n_cmp++;
    if (extra_done != 0) begin
      n_bad++;
      $display("FAIL ignore_start_queue: got %0d active cycles required 0", extra_done);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    @(negedge clk);
    drive(8, 16'h5A, 16'h3C, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(8, 16'h10, 16'h20, 1'b1, 1'b1);
    end
    @(negedge clk);
    n_cmp++;
    if ({b8.done, b8.sum} !== {1'b1, 8'h96}) begin
      n_bad++;
      $display("FAIL b2b_first: got done=%b sum=%h required done=1 sum=96", b8.done, b8.sum);
    end
    @(negedge clk);
    drive(8, 16'h00, 16'h00, 1'b0, 1'b0);
    n_cmp++;
    if ({b8.busy, b8.sum} !== {1'b1, 8'h96}) begin
      n_bad++;
      $display("FAIL b2b_hold: got busy=%b sum=%h required busy=1 sum=96", b8.busy, b8.sum);
    end
    lat = 0;
    while (!b8.done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    n_cmp++;
    if ({b8.sum, b8.cout, b8.ovf} !== {8'hF0, 1'b0, 1'b0} || lat != 4) begin
      n_bad++;
      $display("FAIL b2b_second: got sum=%h cout=%b ovf=%b lat=%0d required sum=f0 cout=0 ovf=0 lat=4",
               b8.sum, b8.cout, b8.ovf, lat);
    end
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    logic [15:0] s; logic c, o; int lat;
    @(negedge clk);
    drive(8, 16'hFF, 16'h01, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(8, 16'hFF, 16'h01, 1'b0, 1'b0);
    end
    #1 rst = 1'b1;
    #1;
    n_cmp++;
    if ({b8.busy, b8.done, b8.sum, b8.cout, b8.ovf} !== 11'd0) begin
      n_bad++;
      $display("FAIL reset_mid: got %b required 0", {b8.busy, b8.done, b8.sum, b8.cout, b8.ovf});
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (b8.done || b8.busy) seen++;
    end
    n_cmp++;
    if (seen != 0) begin
      n_bad++;
      $display("FAIL reset_mid_nodone: got %0d active cycles required 0", seen);
    end
    run_op(8, 16'hFF, 16'h01, 1'b0, s, c, o, lat);
    n_cmp++;
    if ({s[7:0], c, o} !== {8'h00, 1'b1, 1'b0} || lat != 4) begin
      n_bad++;
      $display("FAIL reset_mid_fresh: got sum=%h cout=%b ovf=%b lat=%0d required sum=00 cout=1 ovf=0 lat=4",
               s[7:0], c, o, lat);
    end
  endtask

  task automatic test_w2_exhaustive();
    logic [15:0] s, es; logic c, o, ec, eo; int lat;
    for (int sb = 0; sb < 2; sb++)
      for (int a = 0; a < 4; a++)
        for (int b = 0; b < 4; b++) begin
          run_op(2, 16'(a), 16'(b), 1'(sb), s, c, o, lat);
          model(2, 16'(a), 16'(b), 1'(sb), es, ec, eo);
          n_cmp++;
          if ({s[1:0], c, o} !== {es[1:0], ec, eo} || lat != 1) begin
            n_bad++;
            $display("FAIL w2 a=%0d b=%0d sub=%0d: got %b%b%b lat=%0d required %b%b%b lat=1",
                     a, b, sb, s[1:0], c, o, lat, es[1:0], ec, eo);
          end
        end
  endtask

  task automatic test_random(input int w, input int n);
    logic [15:0] a, b, s, es, mask; logic sub, c, o, ec, eo; int lat;
    mask = 16'((32'd1 << w) - 1);
    for (int i = 0; i < n; i++) begin
      a = 16'($urandom) & mask; b = 16'($urandom) & mask; sub = 1'($urandom);
      run_op(w, a, b, sub, s, c, o, lat);
      model(w, a, b, sub, es, ec, eo);
      n_cmp++;
      if ({s, c, o} !== {es, ec, eo} || lat != w / 2) begin
        n_bad++;
        $display("FAIL rand_w%0d a=%h b=%h sub=%b: got sum=%h cout=%b ovf=%b lat=%0d required sum=%h cout=%b ovf=%b lat=%0d",
                 w, a, b, sub, s, c, o, lat, es, ec, eo, w / 2);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    test_w2_exhaustive();
    test_random(8, 1000);
    test_random(16, 1000);
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
